dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Multi-cycle data-memory access controller between the pipeline's MEM stage and a handshaked data-memory bus. It converts the MEM stage's single-cycle read and write requests (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`) into a req/ack bus transaction and returns read data on `mem_din`. It raises `mem_stall` so the pipeline controller freezes all stages until the access completes. It also flags misaligned and timed-out accesses.

## Interface
- `TIMEOUT_CYC`, default 255: bus cycles waited for `bus_ack` before the access is abandoned.
- `ERR_RDATA`, default 32'hDEAD_BEEF: value returned on `mem_din` for an abandoned read.
- `clk` in 1: main clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: MEM stage holds a valid instruction.
- `mem_ren` in 1: MEM stage read request.
- `mem_wen` in 1: MEM stage write request.
- `mem_addr` in 32: byte address.
- `mem_dout` in 32: write data.
- `pipe_adv` in 1: MEM stage register loads at the next edge (controller's `mem_en` and not `mem_rst`).
- `mem_din` out 32: read data to the MEM stage.
- `mem_stall` out 1: freeze request to the pipeline controller.
- `mem_err` out 1: the access that just completed was misaligned or timed out.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write.
- `bus_addr` out 30: word address, byte address [31:2].
- `bus_wdata` out 32: bus write data.
- `bus_ack` in 1: bus completion, one cycle.
- `bus_rdata` in 32: valid when `bus_ack` is high.

## Operation
- `access = mem_valid & (mem_ren | mem_wen)`. If both strobes are set, the access is treated as a write.
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - `mem_stall = access`.
  - If `access` and `mem_addr[1:0]==0`: latch address, write data and we; set `bus_req`; go to BUSY. The timeout counter loads 0.
  - If `access` and the address is misaligned: no bus cycle; set `err_q`, set `rdata_q=0`, go to DONE.
- **BUSY**
  - `mem_stall=1`.
  - `bus_req` stays high and the latched `bus_addr`/`bus_we`/`bus_wdata` stay stable until ack.
  - On `bus_ack`: `rdata_q <= bus_rdata` for reads (unchanged for writes), `err_q=0`, drop `bus_req`, go to DONE.
  - If the counter reaches `TIMEOUT_CYC-1` without ack: drop `bus_req`, set `err_q=1`, `rdata_q=ERR_RDATA`, go to DONE.
  - The counter saturates and never wraps.
- **DONE**
  - `mem_stall=0`, `mem_din=rdata_q`, `mem_err=err_q`.
  - Go to IDLE on `pipe_adv`. Otherwise hold, with data and error stable. This guarantees the same instruction is never issued twice when another hazard holds the pipeline.
- `mem_din` is `rdata_q` in every state. The MEM stage only samples it in DONE.
- `bus_ack` outside BUSY is ignored.
- Reset mid-transaction: the FSM returns to IDLE immediately and `bus_req` drops. The bus must tolerate the abandoned request.

## Timing
- Reset values:
  - state IDLE; `bus_req`, `bus_we` = 0; `bus_addr`, `bus_wdata` = 0.
  - `rdata_q` = 0, so `mem_din` = 0.
  - `err_q` = 0, so `mem_err` = 0.
  - counter = 0.
  - `mem_stall` is forced to 0 while `rst_n` is low.
- `bus_req` is registered. It first rises the cycle after IDLE sees the access.
- Latency: access seen in cycle 0 and ack in cycle k≥1 gives DONE in cycle k+1. The stall lasts cycles 0..k, so a zero-wait bus (ack in the first req cycle) costs exactly 2 stall cycles.
- Misaligned access: stall in cycle 0 only; DONE in cycle 1.
- Timeout: DONE `TIMEOUT_CYC+1` cycles after the access is seen.
- `mem_stall` depends combinationally on `mem_valid`, `mem_ren`, `mem_wen` and state. No other output is combinational from inputs.
- Back-to-back accesses: after DONE with `pipe_adv`, the next access is recognised in the following IDLE cycle.

## Structure
- FSM state encodings (`DM_IDLE`, `DM_BUSY`, `DM_DONE`) and the `ERR_RDATA` default belong in the shared define header next to the other pipeline constants.
- One natural sub-module, `dmem_timeout_cnt`: a saturating counter with clear, enable and terminal-count output. It is reusable by the instruction-side fetch controller.

## Test plan
- Read at 0x0000_0010, bus acks 3 cycles after req with 0x1234_5678 -> `mem_stall` high for 4 cycles; DONE shows `mem_din`=0x1234_5678, `mem_err`=0; exactly one `bus_req` burst.
- Write 0xCAFE_F00D to 0x0000_0020, zero-wait ack -> `bus_we`=1, `bus_addr`=0x8, `bus_wdata`=0xCAFE_F00D; 2 stall cycles.
- Read at 0x0000_0013 -> no `bus_req`; 1 stall cycle; DONE `mem_din`=0, `mem_err`=1.
- Read with no ack, `TIMEOUT_CYC`=4 -> `bus_req` high 4 cycles then low; `mem_din`=0xDEAD_BEEF, `mem_err`=1.
- DONE with `pipe_adv` held low for 3 cycles -> stays in DONE, no second request, data stable; leaves on `pipe_adv`.
- `rst_n` pulsed low during BUSY -> `bus_req` drops asynchronously; IDLE after release; a stray late `bus_ack` is ignored.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants for the data-memory access controller: FSM encodings,
// default timeout and the read data returned for an abandoned access.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  localparam int unsigned DM_TIMEOUT_CYC = 255;
  localparam logic [31:0] DM_ERR_RDATA   = 32'hDEAD_BEEF;

  function automatic logic dm_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Saturating up-counter with synchronous clear and enable; tc_o flags the terminal count.
module dmem_timeout_cnt #(
  parameter int unsigned Width = 8,
  parameter int unsigned Max   = 254
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MaxVal)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == MaxVal);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Converts single-cycle MEM-stage loads/stores into req/ack bus transactions,
// stalling the pipeline until the access completes, misaligns or times out.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DM_TIMEOUT_CYC,
  parameter logic [31:0] ERR_RDATA   = DM_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic        pipe_adv,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned CntMax = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  dm_state_e   state_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [29:0] bus_addr_q;
  logic [31:0] bus_wdata_q;

  logic access;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  assign access  = mem_valid & (mem_ren | mem_wen);
  assign cnt_clr = (state_q != DM_BUSY);
  assign cnt_en  = (state_q == DM_BUSY) & ~bus_ack;

  dmem_timeout_cnt #(
    .Width (CntW),
    .Max   (CntMax)
  ) u_timeout_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DM_IDLE;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      unique case (state_q)
        DM_IDLE: begin
          if (access) begin
            if (dm_aligned(mem_addr[1:0])) begin
              // A simultaneous read and write strobe is treated as a write.
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_wen;
              bus_addr_q  <= mem_addr[31:2];
              bus_wdata_q <= mem_dout;
              state_q     <= DM_BUSY;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= DM_DONE;
            end
          end
        end
        DM_BUSY: begin
          if (bus_ack) begin
            if (!bus_we_q) rdata_q <= bus_rdata;
            err_q     <= 1'b0;
            bus_req_q <= 1'b0;
            state_q   <= DM_DONE;
          end else if (cnt_tc) begin
            err_q     <= 1'b1;
            rdata_q   <= ERR_RDATA;
            bus_req_q <= 1'b0;
            state_q   <= DM_DONE;
          end
        end
        DM_DONE: begin
          // Hold until the MEM stage actually advances so a stalled pipeline never re-issues.
          if (pipe_adv) state_q <= DM_IDLE;
        end
        default: state_q <= DM_IDLE;
      endcase
    end
  end

  assign mem_stall = rst_n & (((state_q == DM_IDLE) & access) | (state_q == DM_BUSY));
  assign mem_din   = rdata_q;
  assign mem_err   = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected completions are queued as accesses are driven
// and popped when the controller reaches DONE.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_valid, mem_ren, mem_wen, pipe_adv;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_stall, mem_err;
  logic        bus_req, bus_we, bus_ack;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;

  typedef struct {
    logic [31:0] din;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  dmem_access_ctrl #(
    .TIMEOUT_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .pipe_adv  (pipe_adv),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .mem_err   (mem_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one access from IDLE until mem_stall drops (DONE); acks on the ack_on-th req cycle
  // (0 = never). Leaves mem_valid asserted and pipe_adv low.
  task automatic run_access(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_on,
                            input logic [31:0] ack_data, output int stalls, output int reqs,
                            output int bursts, output logic we_seen,
                            output logic [29:0] addr_seen, output logic [31:0] wdata_seen);
    logic prev_req;
    bit   done;
    prev_req = 1'b0; done = 1'b0;
    stalls = 0; reqs = 0; bursts = 0;
    we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
    mem_valid = 1'b1; mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata;
    pipe_adv = 1'b0;
    for (int c = 0; c < 50; c++) begin
      bus_ack   = 1'b0;
      bus_rdata = ~ack_data;
      if (bus_req) begin
        reqs++;
        if (!prev_req) bursts++;
        we_seen = bus_we; addr_seen = bus_addr; wdata_seen = bus_wdata;
        if (reqs == ack_on) begin
          bus_ack = 1'b1; bus_rdata = ack_data;
        end
      end
      prev_req = bus_req;
      #1;
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL access_bound: addr=%h never reached DONE within 50 cycles (required DONE)", addr);
    end
  endtask

  task automatic advance();
    pipe_adv = 1'b1;
    @(posedge clk); #1;
    pipe_adv = 1'b0; mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0;
    mem_addr = 32'h10; mem_dout = 32'h0; pipe_adv = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    n_tests += 7;
    if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus_req); end
    if (bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus_we); end
    if (bus_addr !== 30'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus_addr); end
    if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus_wdata); end
    if (mem_din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", mem_din); end
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", mem_err); end
    mem_valid = 1'b0; mem_ren = 1'b0;
    rst_n = 1'b1;
    model_rdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_wait();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    model_rdata = 32'h1234_5678;
    sb_q.push_back('{din: model_rdata, err: 1'b0});
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, st, rq, bu, we, ad, wd);
    e = sb_q.pop_front();
    n_tests += 7;
    if (st !== 4) begin n_fail++; $display("FAIL rd_stall_cycles: got %0d want 4", st); end
    if (bu !== 1) begin n_fail++; $display("FAIL rd_bursts: got %0d want 1", bu); end
    if (rq !== 3) begin n_fail++; $display("FAIL rd_req_cycles: got %0d want 3", rq); end
    if (we !== 1'b0) begin n_fail++; $display("FAIL rd_we: got %b want 0", we); end
    if (ad !== 30'h4) begin n_fail++; $display("FAIL rd_addr: got %h want 4", ad); end
    if (mem_din !== e.din) begin n_fail++; $display("FAIL rd_din: got %h want %h", mem_din, e.din); end
    if (mem_err !== e.err) begin n_fail++; $display("FAIL rd_err: got %b want %b", mem_err, e.err); end
    advance();
  endtask

  task automatic test_write_zero_wait();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    sb_q.push_back('{din: model_rdata, err: 1'b0});
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h5555_AAAA, st, rq, bu, we, ad, wd);
    e = sb_q.pop_front();
    n_tests += 6;
    if (st !== 2) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d want 2", st); end
    if (we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", we); end
    if (ad !== 30'h8) begin n_fail++; $display("FAIL wr_addr: got %h want 8", ad); end
    if (wd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_wdata: got %h want cafef00d", wd); end
    if (mem_din !== e.din) begin n_fail++; $display("FAIL wr_din_kept: got %h want %h", mem_din, e.din); end
    if (mem_err !== e.err) begin n_fail++; $display("FAIL wr_err: got %b want %b", mem_err, e.err); end
    advance();
  endtask

  task automatic test_misaligned();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    model_rdata = 32'h0;
    sb_q.push_back('{din: 32'h0, err: 1'b1});
    run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h9999_9999, st, rq, bu, we, ad, wd);
    e = sb_q.pop_front();
    n_tests += 4;
    if (rq !== 0) begin n_fail++; $display("FAIL mis_req_cycles: got %0d want 0", rq); end
    if (st !== 1) begin n_fail++; $display("FAIL mis_stall_cycles: got %0d want 1", st); end
    if (mem_din !== e.din) begin n_fail++; $display("FAIL mis_din: got %h want %h", mem_din, e.din); end
    if (mem_err !== e.err) begin n_fail++; $display("FAIL mis_err: got %b want %b", mem_err, e.err); end
    advance();
  endtask

  task automatic test_timeout();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    model_rdata = 32'hDEAD_BEEF;
    sb_q.push_back('{din: 32'hDEAD_BEEF, err: 1'b1});
    run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0, st, rq, bu, we, ad, wd);
    e = sb_q.pop_front();
    n_tests += 6;
    if (rq !== 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", rq); end
    if (bu !== 1) begin n_fail++; $display("FAIL to_bursts: got %0d want 1", bu); end
    if (st !== 5) begin n_fail++; $display("FAIL to_stall_cycles: got %0d want 5", st); end
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL to_req_low: got %b want 0", bus_req); end
    if (mem_din !== e.din) begin n_fail++; $display("FAIL to_din: got %h want %h", mem_din, e.din); end
    if (mem_err !== e.err) begin n_fail++; $display("FAIL to_err: got %b want %b", mem_err, e.err); end
    advance();
  endtask

  task automatic test_hold_done();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    model_rdata = 32'hA5A5_0F0F;
    sb_q.push_back('{din: model_rdata, err: 1'b0});
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2, 32'hA5A5_0F0F, st, rq, bu, we, ad, wd);
    e = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests += 4;
      if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall[%0d]: got %b want 0", i, mem_stall); end
      if (bus_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %b want 0", i, bus_req); end
      if (mem_din !== e.din) begin n_fail++; $display("FAIL hold_din[%0d]: got %h want %h", i, mem_din, e.din); end
      if (mem_err !== e.err) begin n_fail++; $display("FAIL hold_err[%0d]: got %b want %b", i, mem_err, e.err); end
    end
    advance();
    @(posedge clk); #1;
    n_tests += 2;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL hold_no_reissue: got %b want 0", bus_req); end
    if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL hold_idle_stall: got %b want 0", mem_stall); end
  endtask

  task automatic test_both_strobes();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    sb_q.push_back('{din: model_rdata, err: 1'b0});
    run_access(1'b1, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, 2, 32'h1111_2222, st, rq, bu, we, ad, wd);
    e = sb_q.pop_front();
    n_tests += 4;
    if (we !== 1'b1) begin n_fail++; $display("FAIL both_we: got %b want 1", we); end
    if (ad !== 30'h41) begin n_fail++; $display("FAIL both_addr: got %h want 41", ad); end
    if (st !== 3) begin n_fail++; $display("FAIL both_stall_cycles: got %0d want 3", st); end
    if (mem_din !== e.din) begin n_fail++; $display("FAIL both_din: got %h want %h", mem_din, e.din); end
    advance();
  endtask

  task automatic test_back_to_back();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    logic [31:0] data [2];
    data[0] = 32'h0102_0304; data[1] = 32'hF0E0_D0C0;
    for (int i = 0; i < 2; i++) begin
      model_rdata = data[i];
      sb_q.push_back('{din: data[i], err: 1'b0});
      run_access(1'b1, 1'b0, 32'h0000_0200 + 32'(i * 4), 32'h0, 1, data[i], st, rq, bu, we, ad, wd);
      e = sb_q.pop_front();
      n_tests += 3;
      if (st !== 2) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %0d want 2", i, st); end
      if (ad !== 30'(32'h80 + i)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, ad, 30'(32'h80 + i)); end
      if (mem_din !== e.din) begin n_fail++; $display("FAIL b2b_din[%0d]: got %h want %h", i, mem_din, e.din); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int st, rq, bu; logic we; logic [29:0] ad; logic [31:0] wd; exp_t e;
    mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h50;
    @(posedge clk); #1;
    n_tests++;
    if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_up: got %b want 1", bus_req); end
    #2 rst_n = 1'b0;
    #1;
    n_tests += 2;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_async: got %b want 0", bus_req); end
    if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", mem_stall); end
    #1;
    mem_valid = 1'b0; mem_ren = 1'b0;
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    n_tests += 4;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_req: got %b want 0", bus_req); end
    if (mem_din !== 32'h0) begin n_fail++; $display("FAIL rstmid_stray_din: got %h want 0", mem_din); end
    if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", mem_err); end
    if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_stall: got %b want 0", mem_stall); end
    model_rdata = 32'h0BAD_CAFE;
    sb_q.push_back('{din: model_rdata, err: 1'b0});
    run_access(1'b1, 1'b0, 32'h0000_0060, 32'h0, 1, 32'h0BAD_CAFE, st, rq, bu, we, ad, wd);
    e = sb_q.pop_front();
    n_tests += 2;
    if (st !== 2) begin n_fail++; $display("FAIL rstmid_after_stall: got %0d want 2", st); end
    if (mem_din !== e.din) begin n_fail++; $display("FAIL rstmid_after_din: got %h want %h", mem_din, e.din); end
    advance();
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write_zero_wait();
    test_misaligned();
    test_timeout();
    test_hold_done();
    test_both_strobes();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
